// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and default byte width.
package uart_ctrl_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: the first set request strictly after ptr, wrapping at NUM_REQ.
module uart_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         win_onehot,
    output logic [$clog2(NUM_REQ)-1:0] win_idx
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic             found;
    logic [PTR_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        // k runs 1..NUM_REQ so the last client searched is the previous winner itself.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found             = 1'b1;
                win_onehot[cand]  = 1'b1;
                win_idx           = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one TX buffer + UART_Tx among NUM_REQ clients.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      load,
    output logic                      SEND,
    output logic [DATA_W-1:0]         Tx_Data,
    input  logic                      NINTO,
    output logic                      busy,
    output logic                      timeout_err,
    input  logic                      err_clr
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    tx_state_e          state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]  tx_data_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               load_nxt;
    logic               send_nxt;
    logic               busy_nxt;
    logic               err_set;
    logic               err_nxt;

    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   win_idx;

    uart_rr_arb #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        tx_data_nxt = Tx_Data;
        gnt_nxt     = '0;
        load_nxt    = 1'b0;
        send_nxt    = 1'b0;
        err_set     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt   = ST_LOAD;
                    ptr_nxt     = win_idx;
                    tx_data_nxt = req_data[win_idx*DATA_W +: DATA_W];
                    gnt_nxt     = win_onehot;
                    load_nxt    = 1'b1;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_SEND;
                send_nxt  = 1'b1;
            end
            ST_SEND: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = '0;
            end
            ST_WAIT: begin
                // The done flag may still be low from the previous byte on the first WAIT cycle.
                if (cnt != '0 && !NINTO) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    err_set   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        err_nxt  = err_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            ptr         <= PTR_W'(NUM_REQ - 1);
            cnt         <= '0;
            Tx_Data     <= '0;
            gnt         <= '0;
            load        <= 1'b0;
            SEND        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            Tx_Data     <= tx_data_nxt;
            gnt         <= gnt_nxt;
            load        <= load_nxt;
            SEND        <= send_nxt;
            busy        <= busy_nxt;
            timeout_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-level model checked every cycle, plus directed literal checks.
module tb_uart_tx_sched;

    localparam int NR = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              Clock;
    logic              Reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic              load;
    logic              SEND;
    logic [DW-1:0]     Tx_Data;
    logic              NINTO;
    logic              busy;
    logic              timeout_err;
    logic              err_clr;

    uart_tx_sched #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .load        (load),
        .SEND        (SEND),
        .Tx_Data     (Tx_Data),
        .NINTO       (NINTO),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer model: a transfer is "active" from its grant cycle (age 0); SEND is age 1;
    // waiting for the done flag starts at age 2.
    bit          m_active = 1'b0;
    int          m_age    = 0;
    int          m_last   = NR - 1;
    logic [DW-1:0] m_byte = '0;
    bit          m_err    = 1'b0;

    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++)
            if (r[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_last   = NR - 1;
        m_byte   = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_step();
        bit done;
        bit set_err;
        int w;
        done    = 1'b0;
        set_err = 1'b0;
        if (!m_active) begin
            if (|req) begin
                w        = rr_pick(req, m_last);
                m_last   = w;
                m_byte   = req_data[w*DW +: DW];
                m_active = 1'b1;
                m_age    = 0;
            end
        end else begin
            if (m_age >= 2) begin
                w = m_age - 2;
                if (w >= 1 && NINTO == 1'b0) done = 1'b1;
                else if (w == TO - 1) begin
                    done    = 1'b1;
                    set_err = 1'b1;
                end
            end
            if (done) m_active = 1'b0;
            else m_age++;
        end
        if (set_err) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge Clock or posedge Reset);
            if (Reset) model_reset();
            else model_step();
        end
    end

    logic [NR-1:0] e_gnt;

    initial begin
        forever begin
            @(negedge Clock);
            e_gnt = '0;
            if (m_active && m_age == 0) e_gnt[m_last] = 1'b1;
            check("cmp gnt",  32'(gnt),  32'(e_gnt));
            check("cmp load", 32'(load), 32'(m_active && m_age == 0));
            check("cmp SEND", 32'(SEND), 32'(m_active && m_age == 1));
            check("cmp busy", 32'(busy), 32'(m_active));
            check("cmp Tx_Data", 32'(Tx_Data), 32'(m_byte));
            check("cmp timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic wait_load(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge Clock);
            if (load === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_load bound", 32'(load), 32'd1);
    endtask

    int  g1cnt;
    bit  hold_hi;

    initial begin
        Reset    = 1'b1;
        req      = '0;
        req_data = '0;
        NINTO    = 1'b1;
        err_clr  = 1'b0;

        // Reset values
        @(negedge Clock);
        check("rst busy", 32'(busy), 32'd0);
        check("rst gnt", 32'(gnt), 32'd0);
        check("rst Tx_Data", 32'(Tx_Data), 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        tick();
        Reset = 1'b0;

        // Single byte A5, done flag low at WAIT cycle 3
        req = 3'b001;
        req_data[0 +: DW] = 8'hA5;
        @(negedge Clock);
        check("t2 busy before grant", 32'(busy), 32'd0);
        tick(); req = '0;
        @(negedge Clock);
        check("t2 gnt", 32'(gnt), 32'b001);
        check("t2 load", 32'(load), 32'd1);
        check("t2 Tx_Data", 32'(Tx_Data), 32'hA5);
        tick();
        @(negedge Clock);
        check("t2 SEND", 32'(SEND), 32'd1);
        check("t2 load off", 32'(load), 32'd0);
        repeat (4) tick();
        NINTO = 1'b0;
        @(negedge Clock);
        check("t2 busy in WAIT", 32'(busy), 32'd1);
        tick(); NINTO = 1'b1;
        @(negedge Clock);
        check("t2 busy low t+7", 32'(busy), 32'd0);

        // Done flag low only in the first WAIT cycle is ignored
        req = 3'b001;
        req_data[0 +: DW] = 8'h3C;
        tick(); req = '0;
        tick();
        tick(); NINTO = 1'b0;
        tick(); NINTO = 1'b1;
        @(negedge Clock);
        check("t5 no early exit", 32'(busy), 32'd1);
        tick(); NINTO = 1'b0;
        @(negedge Clock);
        check("t5 still busy", 32'(busy), 32'd1);
        tick(); NINTO = 1'b1;
        @(negedge Clock);
        check("t5 done", 32'(busy), 32'd0);

        // Timeout after 16 WAIT cycles, then clear
        req = 3'b001;
        tick(); req = '0;
        repeat (17) tick();
        @(negedge Clock);
        check("t4 busy last WAIT", 32'(busy), 32'd1);
        check("t4 err not yet", 32'(timeout_err), 32'd0);
        tick();
        @(negedge Clock);
        check("t4 busy after timeout", 32'(busy), 32'd0);
        check("t4 err set", 32'(timeout_err), 32'd1);
        tick(); err_clr = 1'b1;
        @(negedge Clock);
        check("t4 err sticky", 32'(timeout_err), 32'd1);
        tick(); err_clr = 1'b0;
        @(negedge Clock);
        check("t4 err cleared", 32'(timeout_err), 32'd0);

        // Set wins over a simultaneous clear
        req = 3'b001; err_clr = 1'b1;
        tick(); req = '0;
        repeat (17) tick();
        @(negedge Clock);
        check("t4b err held clear", 32'(timeout_err), 32'd0);
        tick(); err_clr = 1'b0;
        @(negedge Clock);
        check("t4b set wins", 32'(timeout_err), 32'd1);

        // Async reset mid-WAIT
        req = 3'b010;
        req_data[DW +: DW] = 8'h5A;
        tick(); req = '0;
        repeat (3) tick();
        Reset = 1'b1;
        #1;
        check("t1 busy async", 32'(busy), 32'd0);
        check("t1 load async", 32'(load), 32'd0);
        check("t1 SEND async", 32'(SEND), 32'd0);
        check("t1 gnt async", 32'(gnt), 32'd0);
        check("t1 err async", 32'(timeout_err), 32'd0);
        check("t1 Tx_Data async", 32'(Tx_Data), 32'd0);
        tick(); Reset = 1'b0;

        // Two continuous requesters alternate, starting at client 0
        req = 3'b011;
        req_data[0 +: DW]  = 8'h11;
        req_data[DW +: DW] = 8'h22;
        NINTO = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_load(12);
            check("t3 gnt order", 32'(gnt), (k % 2 == 0) ? 32'b001 : 32'b010);
            check("t3 Tx_Data", 32'(Tx_Data), (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        tick(); req = '0;
        repeat (6) tick();
        NINTO = 1'b1;

        // req[1] toggling outside IDLE is ignored
        g1cnt = 0;
        req = 3'b001;
        tick(); req = 3'b010;
        @(negedge Clock);
        check("t6 gnt client 0", 32'(gnt), 32'b001);
        g1cnt += int'(gnt[1]);
        tick(); req = '0;
        @(negedge Clock); g1cnt += int'(gnt[1]);
        tick(); req = 3'b010;
        @(negedge Clock); g1cnt += int'(gnt[1]);
        tick(); req = '0; NINTO = 1'b0;
        @(negedge Clock); g1cnt += int'(gnt[1]);
        tick(); NINTO = 1'b1;
        @(negedge Clock);
        g1cnt += int'(gnt[1]);
        check("t6 idle after transfer", 32'(busy), 32'd0);
        check("t6 no gnt1 while busy", 32'(g1cnt), 32'd0);
        tick(); req = 3'b010;
        tick(); req = '0;
        @(negedge Clock);
        check("t6 gnt client 1 next", 32'(gnt), 32'b010);
        repeat (3) tick();
        NINTO = 1'b0;
        tick(); NINTO = 1'b1;

        // Randomized traffic against the model
        hold_hi = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (c % 64 == 0) hold_hi = ($urandom_range(0, 3) == 0);
            Reset    = ($urandom_range(0, 299) == 0);
            req      = NR'($urandom_range(0, (1 << NR) - 1));
            req_data = (NR*DW)'($urandom);
            NINTO    = hold_hi ? 1'b1 : ($urandom_range(0, 2) != 0);
            err_clr  = ($urandom_range(0, 15) == 0);
        end
        tick();
        Reset = 1'b0; req = '0; NINTO = 1'b0; err_clr = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
